ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline, between ID and MEM. Registers the ID->EX bus under

---
 rtl/ex_stage_pkg.sv | 87 ++++++++
 rtl/ex_stage_if.sv | 30 +++
 rtl/ex_stage_div_iter.sv | 87 ++++++++
 rtl/ex_stage.sv | 113 +++++++++++
 tb/tb_ex_stage.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the EX stage: bus layouts, stall vector,
// ALU/operand select bit positions, divider encodings and FSM states.
package ex_stage_pkg;

  localparam int DIV_CYCLES_DEFAULT = 32;

  // Stall vector: one bit per pipeline stage, STOP freezes that stage
  typedef logic [5:0] stall_bus_t;
  localparam logic STOP     = 1'b1;
  localparam logic NO_STOP  = 1'b0;
  localparam int   STALL_ID = 2;
  localparam int   STALL_EX = 3;

  // One-hot alu_op bit positions, add is the most significant bit
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  // One-hot operand selects
  localparam int SRC1_RS    = 0;
  localparam int SRC1_PC    = 1;
  localparam int SRC1_SA    = 2;
  localparam int SRC2_RT    = 0;
  localparam int SRC2_SIMM  = 1;
  localparam int SRC2_EIGHT = 2;
  localparam int SRC2_ZIMM  = 3;

  localparam logic [1:0] DIV_OP_DIV  = 2'b10;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  typedef struct packed {
    logic [1:0]  div_op;
    logic [1:0]  mem_op;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  typedef struct packed {
    logic [1:0]  mem_op;
    logic [31:0] pc;
    logic        ram_en;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] ex_result;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } ex_to_mem_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_rf_t;

  localparam int ID_TO_EX_WD  = $bits(id_to_ex_t);
  localparam int EX_TO_MEM_WD = $bits(ex_to_mem_t);
  localparam int EX_TO_RF_WD  = $bits(ex_to_rf_t);

  // Magnitude of a value; unsigned operands pass through untouched
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of the EX stage pipeline buses, forwarding, stall and data SRAM signals.
interface ex_stage_if;
  import ex_stage_pkg::*;

  stall_bus_t  stall;
  id_to_ex_t   id_to_ex_bus;
  ex_to_mem_t  ex_to_mem_bus;
  ex_to_rf_t   ex_to_rf_bus;
  logic        ex_is_load;
  logic        stallreq_for_ex;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  // Pipeline side: drives stall and the ID bus, observes everything EX produces
  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_rf_bus, ex_is_load, stallreq_for_ex,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  // EX stage side
  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_rf_bus, ex_is_load, stallreq_for_ex,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle. Results are
// sign-corrected on the last step so quo/rem are final while done is high.
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic        hold,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  div_state_e  state;
  logic [4:0]  cnt;
  logic [31:0] divisor;
  logic        sign_q;
  logic        sign_r;
  logic        div_zero;
  logic [33:0] trial;
  logic [31:0] step_quo;
  logic [31:0] step_rem;
  logic        unused_trial;

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);
  assign unused_trial = trial[32];

  // One restoring step: shift the next dividend bit in and try to subtract
  always_comb begin
    trial    = {1'b0, rem, quo[31]} - {2'b00, divisor};
    step_quo = {quo[30:0], ~trial[33]};
    step_rem = trial[33] ? {rem[30:0], quo[31]} : trial[31:0];
  end

  // Divider FSM; divide by zero leaves the quotient unsigned and the remainder equal to the dividend
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      divisor  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      quo      <= '0;
      rem      <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            quo      <= abs32(a, signed_op);
            rem      <= '0;
            divisor  <= abs32(b, signed_op);
            sign_q   <= signed_op & (a[31] ^ b[31]);
            sign_r   <= signed_op & a[31];
            div_zero <= (b == 32'd0);
            cnt      <= '0;
            state    <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_CYCLES - 1)) begin
            quo   <= (sign_q && !div_zero) ? (~step_quo + 32'd1) : step_quo;
            rem   <= sign_r ? (~step_rem + 32'd1) : step_rem;
            state <= DIV_DONE;
          end else begin
            quo <= step_quo;
            rem <= step_rem;
          end
        end
        DIV_DONE: begin
          if (!hold) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID->EX register, ALU, data SRAM request, forwarding bus and
// the iterative divider that freezes the front of the pipeline while it runs.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  ex_stage_if.slave   bus
);

  id_to_ex_t   ex_r;
  logic [15:0] imm;
  logic [4:0]  sa;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;
  logic        is_load;
  logic        stallreq;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        unused_bits;

  // ID->EX register: bubble when ID holds but EX moves, capture when ID moves, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else if (bus.stall[STALL_ID] == STOP && bus.stall[STALL_EX] == NO_STOP) begin
      ex_r <= '0;
    end else if (bus.stall[STALL_ID] == NO_STOP) begin
      ex_r <= bus.id_to_ex_bus;
    end
  end

  assign imm = ex_r.inst[15:0];
  assign sa  = ex_r.inst[10:6];
  assign unused_bits = ^{ex_r.inst[31:16], bus.stall[5:4], bus.stall[1:0]};

  // Operand muxes and one-hot ALU; an empty select or op yields zero
  always_comb begin
    src1 = ({32{ex_r.sel_src1[SRC1_RS]}} & ex_r.rdata1)
         | ({32{ex_r.sel_src1[SRC1_PC]}} & ex_r.pc)
         | ({32{ex_r.sel_src1[SRC1_SA]}} & {27'd0, sa});
    src2 = ({32{ex_r.sel_src2[SRC2_RT]}}    & ex_r.rdata2)
         | ({32{ex_r.sel_src2[SRC2_SIMM]}}  & {{16{imm[15]}}, imm})
         | ({32{ex_r.sel_src2[SRC2_EIGHT]}} & 32'd8)
         | ({32{ex_r.sel_src2[SRC2_ZIMM]}}  & {16'd0, imm});
    alu_result = '0;
    if (ex_r.alu_op[ALU_ADD])  alu_result = alu_result | (src1 + src2);
    if (ex_r.alu_op[ALU_SUB])  alu_result = alu_result | (src1 - src2);
    if (ex_r.alu_op[ALU_SLT])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
    if (ex_r.alu_op[ALU_SLTU]) alu_result = alu_result | {31'd0, src1 < src2};
    if (ex_r.alu_op[ALU_AND])  alu_result = alu_result | (src1 & src2);
    if (ex_r.alu_op[ALU_NOR])  alu_result = alu_result | ~(src1 | src2);
    if (ex_r.alu_op[ALU_OR])   alu_result = alu_result | (src1 | src2);
    if (ex_r.alu_op[ALU_XOR])  alu_result = alu_result | (src1 ^ src2);
    if (ex_r.alu_op[ALU_SLL])  alu_result = alu_result | (src2 << src1[4:0]);
    if (ex_r.alu_op[ALU_SRL])  alu_result = alu_result | (src2 >> src1[4:0]);
    if (ex_r.alu_op[ALU_SRA])  alu_result = alu_result | 32'($signed(src2) >>> src1[4:0]);
    if (ex_r.alu_op[ALU_LUI])  alu_result = alu_result | {imm, 16'd0};
  end

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (ex_r.div_op != 2'b00),
    .signed_op (ex_r.div_op == DIV_OP_DIV),
    .hold      (bus.stall[STALL_EX] == STOP),
    .a         (ex_r.rdata1),
    .b         (ex_r.rdata2),
    .busy      (div_busy),
    .done      (div_done),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  // The stall request rises in the very cycle a divide arrives so nothing behind it moves
  assign stallreq = ((ex_r.div_op != 2'b00) && !div_busy && !div_done) || div_busy;
  assign bus.stallreq_for_ex = stallreq;

  // sel_rf_res marks a load: the register file result comes from memory, not the ALU
  assign is_load        = ex_r.sel_rf_res;
  assign bus.ex_is_load = is_load;

  // A bubble is an all-zero bus, so only the divider stall needs explicit gating here
  assign bus.data_sram_en    = ex_r.ram_en & ~stallreq;
  assign bus.data_sram_wen   = stallreq ? 4'd0  : ex_r.ram_wen;
  assign bus.data_sram_addr  = stallreq ? 32'd0 : (ex_r.rdata1 + {{16{imm[15]}}, imm});
  assign bus.data_sram_wdata = stallreq ? 32'd0 : ex_r.rdata2;

  assign bus.ex_to_mem_bus = '{
    mem_op:     ex_r.mem_op,
    pc:         ex_r.pc,
    ram_en:     ex_r.ram_en,
    rf_we:      ex_r.rf_we,
    rf_waddr:   ex_r.rf_waddr,
    sel_rf_res: ex_r.sel_rf_res,
    ex_result:  alu_result,
    hilo_we:    div_done,
    hi:         div_done ? div_rem : 32'd0,
    lo:         div_done ? div_quo : 32'd0
  };

  assign bus.ex_to_rf_bus = '{
    rf_we:     ex_r.rf_we & ~is_load,
    rf_waddr:  ex_r.rf_waddr,
    ex_result: alu_result
  };

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU ops, SRAM requests, load forwarding,
// divider latency/corner cases, reset mid-divide and result hold under stall.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam stall_bus_t STALL_NONE   = 6'b000000;
  localparam stall_bus_t STALL_BUBBLE = 6'b000111;
  localparam stall_bus_t STALL_HOLD   = 6'b001111;

  logic       clk = 1'b0;
  logic       rst;
  stall_bus_t stall_ext;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;

  ex_stage_if bus();

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model of the pipeline controller: the divider request freezes PC..EX
  assign bus.stall = bus.stallreq_for_ex ? STALL_HOLD : stall_ext;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input id_to_ex_t v, input stall_bus_t s);
    bus.id_to_ex_bus = v;
    stall_ext = s;
    tick();
  endtask

  function automatic id_to_ex_t mk_alu(input logic [11:0] op, input logic [2:0] s1,
                                       input logic [3:0] s2, input logic [31:0] inst,
                                       input logic [31:0] pc, input logic [31:0] r1,
                                       input logic [31:0] r2);
    id_to_ex_t v = '0;
    v.alu_op   = op;
    v.sel_src1 = s1;
    v.sel_src2 = s2;
    v.inst     = inst;
    v.pc       = pc;
    v.rdata1   = r1;
    v.rdata2   = r2;
    return v;
  endfunction

  function automatic logic [11:0] op1(input int b);
    return 12'd1 << b;
  endfunction

  task automatic alu_case(input string tag, input int op, input int s1, input int s2,
                          input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exp);
    logic [11:0] o;
    o = (op < 0) ? 12'd0 : op1(op);
    apply_stimulus(mk_alu(o, 3'(1 << s1), 4'(1 << s2), inst, pc, r1, r2), STALL_NONE);
    check_output(tag, bus.ex_to_mem_bus.ex_result, exp);
  endtask

  task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    id_to_ex_t v = '0;
    int cycles = 0;
    v.div_op = op;
    v.rdata1 = a;
    v.rdata2 = b;
    apply_stimulus(v, STALL_NONE);
    while (bus.stallreq_for_ex && cycles < 100) begin
      cycles++;
      tick();
    end
    check_output({tag, "_stall_cycles"}, 32'(cycles), 32'd33);
    check_output({tag, "_hilo_we"}, 32'(bus.ex_to_mem_bus.hilo_we), 32'd1);
    check_output({tag, "_lo"}, bus.ex_to_mem_bus.lo, exp_lo);
    check_output({tag, "_hi"}, bus.ex_to_mem_bus.hi, exp_hi);
  endtask

  initial begin
    id_to_ex_t v;

    // Reset state
    rst = 1'b1;
    stall_ext = STALL_NONE;
    bus.id_to_ex_bus = '0;
    tick();
    tick();
    check_output("rst_mem_bus_zero", 32'(|bus.ex_to_mem_bus), 32'd0);
    check_output("rst_rf_bus_zero", 32'(|bus.ex_to_rf_bus), 32'd0);
    check_output("rst_stallreq", 32'(bus.stallreq_for_ex), 32'd0);
    check_output("rst_sram", 32'(|{bus.data_sram_en, bus.data_sram_wen,
                                   bus.data_sram_addr, bus.data_sram_wdata}), 32'd0);
    rst = 1'b0;

    // addiu wraps into the sign bit and forwards to rt
    v = mk_alu(op1(ALU_ADD), 3'(1 << SRC1_RS), 4'(1 << SRC2_SIMM), 32'h2422_0001, 32'h0, 32'h7FFF_FFFF, 32'h0);
    v.rf_we = 1'b1;
    v.rf_waddr = 5'd2;
    apply_stimulus(v, STALL_NONE);
    check_output("addiu_result", bus.ex_to_mem_bus.ex_result, 32'h8000_0000);
    check_output("addiu_fwd_we", 32'(bus.ex_to_rf_bus.rf_we), 32'd1);
    check_output("addiu_fwd_waddr", 32'(bus.ex_to_rf_bus.rf_waddr), 32'd2);
    check_output("addiu_fwd_data", bus.ex_to_rf_bus.ex_result, 32'h8000_0000);
    check_output("addiu_stallreq", 32'(bus.stallreq_for_ex), 32'd0);

    // sw with negative offset, then the same bus bubbled away
    v = mk_alu(op1(ALU_ADD), 3'(1 << SRC1_RS), 4'(1 << SRC2_SIMM), 32'hAC00_FFFC, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF);
    v.ram_en = 1'b1;
    v.ram_wen = 4'hF;
    apply_stimulus(v, STALL_NONE);
    check_output("sw_en", 32'(bus.data_sram_en), 32'd1);
    check_output("sw_wen", 32'(bus.data_sram_wen), 32'hF);
    check_output("sw_addr", bus.data_sram_addr, 32'h0000_00FC);
    check_output("sw_wdata", bus.data_sram_wdata, 32'hDEAD_BEEF);
    apply_stimulus(v, STALL_BUBBLE);
    check_output("bubble_en", 32'(bus.data_sram_en), 32'd0);
    check_output("bubble_wen", 32'(bus.data_sram_wen), 32'd0);
    check_output("bubble_addr", bus.data_sram_addr, 32'd0);
    check_output("bubble_wdata", bus.data_sram_wdata, 32'd0);

    // lw: no forwarding, load flagged, read request
    v = mk_alu(op1(ALU_ADD), 3'(1 << SRC1_RS), 4'(1 << SRC2_SIMM), 32'h8C08_0004, 32'h0, 32'h0000_0200, 32'h0);
    v.ram_en = 1'b1;
    v.rf_we = 1'b1;
    v.rf_waddr = 5'd8;
    v.sel_rf_res = 1'b1;
    apply_stimulus(v, STALL_NONE);
    check_output("lw_is_load", 32'(bus.ex_is_load), 32'd1);
    check_output("lw_fwd_we", 32'(bus.ex_to_rf_bus.rf_we), 32'd0);
    check_output("lw_wen", 32'(bus.data_sram_wen), 32'd0);
    check_output("lw_en", 32'(bus.data_sram_en), 32'd1);
    check_output("lw_addr", bus.data_sram_addr, 32'h0000_0204);

    // ALU operations and operand selects
    alu_case("sub",  ALU_SUB,  SRC1_RS, SRC2_RT,    32'h0,         32'h0, 32'd5,         32'd7,         32'hFFFF_FFFE);
    alu_case("slt",  ALU_SLT,  SRC1_RS, SRC2_RT,    32'h0,         32'h0, 32'hFFFF_FFFF, 32'd1,         32'd1);
    alu_case("sltu", ALU_SLTU, SRC1_RS, SRC2_RT,    32'h0,         32'h0, 32'hFFFF_FFFF, 32'd1,         32'd0);
    alu_case("and",  ALU_AND,  SRC1_RS, SRC2_RT,    32'h0,         32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_case("nor",  ALU_NOR,  SRC1_RS, SRC2_RT,    32'h0,         32'h0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
    alu_case("xor",  ALU_XOR,  SRC1_RS, SRC2_RT,    32'h0,         32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu_case("ori",  ALU_OR,   SRC1_RS, SRC2_ZIMM,  32'h3400_8000, 32'h0, 32'h0000_0001, 32'h0,         32'h0000_8001);
    alu_case("sll",  ALU_SLL,  SRC1_SA, SRC2_RT,    32'h0000_0100, 32'h0, 32'h0,         32'h0000_0001, 32'h0000_0010);
    alu_case("srl",  ALU_SRL,  SRC1_SA, SRC2_RT,    32'h0000_0100, 32'h0, 32'h0,         32'h8000_0000, 32'h0800_0000);
    alu_case("sra",  ALU_SRA,  SRC1_SA, SRC2_RT,    32'h0000_0100, 32'h0, 32'h0,         32'h8000_0000, 32'hF800_0000);
    alu_case("lui",  ALU_LUI,  SRC1_RS, SRC2_ZIMM,  32'h3C00_1234, 32'h0, 32'hFFFF_FFFF, 32'h0,         32'h1234_0000);
    alu_case("link", ALU_ADD,  SRC1_PC, SRC2_EIGHT, 32'h0,         32'hBFC0_0000, 32'h0, 32'h0,         32'hBFC0_0008);
    alu_case("noop", -1,       SRC1_RS, SRC2_RT,    32'h0,         32'h0, 32'h1234_5678, 32'h1111_1111, 32'h0);

    // Divider: signs, unsigned, divide by zero, overflow
    run_div("div_m7_2",    DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu_max_16", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 32'h0000_000F);
    run_div("divu_5_0",    DIV_OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5);
    run_div("div_ovf",     DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

    // Reset in the middle of a divide
    v = '0;
    v.div_op = DIV_OP_DIV;
    v.rdata1 = 32'd50;
    v.rdata2 = 32'd3;
    apply_stimulus(v, STALL_NONE);
    repeat (10) tick();
    check_output("busy_before_rst", 32'(bus.stallreq_for_ex), 32'd1);
    rst = 1'b1;
    bus.id_to_ex_bus = '0;
    tick();
    rst = 1'b0;
    check_output("midrst_stallreq", 32'(bus.stallreq_for_ex), 32'd0);
    check_output("midrst_hilo_we", 32'(bus.ex_to_mem_bus.hilo_we), 32'd0);
    check_output("midrst_mem_bus_zero", 32'(|bus.ex_to_mem_bus), 32'd0);

    // Fresh divide after reset, then held in DONE by a downstream stall
    run_div("div_100_7", DIV_OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus('0, STALL_HOLD);
      check_output($sformatf("hold%0d_stallreq", i), 32'(bus.stallreq_for_ex), 32'd0);
      check_output($sformatf("hold%0d_hilo_we", i), 32'(bus.ex_to_mem_bus.hilo_we), 32'd1);
      check_output($sformatf("hold%0d_lo", i), bus.ex_to_mem_bus.lo, 32'd14);
      check_output($sformatf("hold%0d_hi", i), bus.ex_to_mem_bus.hi, 32'd2);
    end
    apply_stimulus('0, STALL_NONE);
    check_output("release_hilo_we", 32'(bus.ex_to_mem_bus.hilo_we), 32'd0);
    check_output("release_stallreq", 32'(bus.stallreq_for_ex), 32'd0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
